// File: rtl/block_drawer.sv
// Scrolling obstacle drawer on the shape-select bus.
// Emits the block rectangle plus a black trailing erase strip, one pixel per cycle.
module block_drawer #(
    parameter int           SCREEN_W = 160,
    parameter int           START_X  = 159,
    parameter int           WRAP_X   = 159,
    parameter int           Y_POS    = 100,
    parameter int           W        = 8,
    parameter int           H        = 8,
    parameter int           STEP     = 1,
    parameter logic [2:0]   COLOUR   = 3'b111
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        draw_start,
    input  logic        update_screen,
    output logic        draw_done,
    output logic [10:0] send_x,
    output logic [10:0] send_y,
    output logic [2:0]  send_colour,
    output logic        plot
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] COL_LAST = 7'(W + STEP - 1);
    localparam logic [5:0] ROW_LAST = 6'(H - 1);
    localparam logic [6:0] COL_W    = 7'(W);

    logic [1:0]  state_q, state_d;
    logic [10:0] x_pos_q, x_pos_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic        move_pending_q, move_pending_d;
    logic        draw_done_q, draw_done_d;
    logic        plot_q, plot_d;
    logic [10:0] send_x_q, send_x_d;
    logic [10:0] send_y_q, send_y_d;
    logic [2:0]  send_colour_q, send_colour_d;

    // Next-state: scroll only in IDLE, walk the pixel raster in DRAW, handshake in DONE.
    always_comb begin
        state_d        = state_q;
        x_pos_d        = x_pos_q;
        col_d          = col_q;
        row_d          = row_q;
        move_pending_d = move_pending_q | update_screen;
        draw_done_d    = 1'b0;
        plot_d         = 1'b0;
        send_x_d       = send_x_q;
        send_y_d       = send_y_q;
        send_colour_d  = send_colour_q;

        case (state_q)
            S_IDLE: begin
                if (move_pending_q | update_screen) begin
                    // A pending move beats a draw request so each run sees a settled x.
                    x_pos_d        = (x_pos_q < 11'(STEP)) ? 11'(WRAP_X)
                                                           : x_pos_q - 11'(STEP);
                    move_pending_d = 1'b0;
                end else if (draw_start) begin
                    state_d = S_DRAW;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_DRAW: begin
                if (!draw_start) begin
                    state_d = S_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    send_x_d      = x_pos_q + 11'(col_q);
                    send_y_d      = 11'(Y_POS) + 11'(row_q);
                    send_colour_d = (col_q < COL_W) ? COLOUR : 3'b000;
                    // 12-bit compare so x_pos+col never wraps into the visible range.
                    plot_d        = ({1'b0, x_pos_q} + 12'(col_q)) < 12'(SCREEN_W);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            S_DONE: begin
                if (draw_start) begin
                    draw_done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            x_pos_q        <= 11'(START_X);
            col_q          <= '0;
            row_q          <= '0;
            move_pending_q <= 1'b0;
            draw_done_q    <= 1'b0;
            plot_q         <= 1'b0;
            send_x_q       <= 11'(START_X);
            send_y_q       <= 11'(Y_POS);
            send_colour_q  <= 3'b000;
        end else begin
            state_q        <= state_d;
            x_pos_q        <= x_pos_d;
            col_q          <= col_d;
            row_q          <= row_d;
            move_pending_q <= move_pending_d;
            draw_done_q    <= draw_done_d;
            plot_q         <= plot_d;
            send_x_q       <= send_x_d;
            send_y_q       <= send_y_d;
            send_colour_q  <= send_colour_d;
        end
    end

    assign draw_done   = draw_done_q;
    assign plot        = plot_q;
    assign send_x      = send_x_q;
    assign send_y      = send_y_q;
    assign send_colour = send_colour_q;

endmodule

// File: tb/tb_block_drawer.sv
// Directed bench for block_drawer with a pixel scoreboard.
module tb_block_drawer;

    logic        clock;
    logic        resetn;
    logic        draw_start;
    logic        update_screen;
    logic        draw_done;
    logic [10:0] send_x;
    logic [10:0] send_y;
    logic [2:0]  send_colour;
    logic        plot;

    int n_checks = 0;
    int n_fail   = 0;
    int xpos     = 159;

    // {draw_done, plot, x, y, colour}
    logic [26:0] exp_q[$];

    block_drawer dut (
        .clock         (clock),
        .resetn        (resetn),
        .draw_start    (draw_start),
        .update_screen (update_screen),
        .draw_done     (draw_done),
        .send_x        (send_x),
        .send_y        (send_y),
        .send_colour   (send_colour),
        .plot          (plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [26:0] obs();
        return {draw_done, plot, send_x, send_y, send_colour};
    endfunction

    task automatic chk(input string tag, input logic [26:0] o, input logic [26:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %07h expected %07h", tag, o, e);
        end
    endtask

    task automatic push_run(input int xp);
        logic [11:0] xs;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 9; c++) begin
                xs = 12'(xp + c);
                exp_q.push_back({1'b0, (xs < 12'd160), xs[10:0],
                                 11'(100 + r), (c < 8) ? 3'b111 : 3'b000});
            end
        end
    endtask

    // Raise draw_start, compare npix pixels; full runs also check DONE.
    task automatic run_draw(input int extra, input bit upd_with_start,
                            input int upd_at, input int npix);
        logic [26:0] e;
        if (upd_with_start) xpos = (xpos < 1) ? 159 : xpos - 1;
        push_run(xpos);
        draw_start    = 1'b1;
        update_screen = upd_with_start;
        for (int k = 0; k <= extra; k++) begin
            @(negedge clock);
            update_screen = 1'b0;
            chk("pre_pixel_idle", {draw_done, plot}, 2'b00);
        end
        for (int i = 0; i < npix; i++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            chk($sformatf("pixel%0d", i), obs(), e);
            update_screen = (i == upd_at);
        end
        update_screen = 1'b0;
        exp_q.delete();
        if (npix == 72) begin
            @(negedge clock);
            chk("done_set", {draw_done, plot}, 2'b10);
            @(negedge clock);
            chk("done_hold", {draw_done, plot}, 2'b10);
        end
    endtask

    task automatic finish_run();
        draw_start = 1'b0;
        @(negedge clock);
        chk("done_clear", {draw_done, plot}, 2'b00);
    endtask

    initial begin
        resetn        = 1'b0;
        draw_start    = 1'b0;
        update_screen = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_state", obs(), {1'b0, 1'b0, 11'd159, 11'd100, 3'b000});
        resetn = 1'b1;

        // Full run at reset position, then restart after DONE.
        run_draw(0, 1'b0, -1, 72);
        finish_run();
        run_draw(0, 1'b0, -1, 72);
        finish_run();

        // Scroll pulse mid-draw: applied after DONE->IDLE, delays next draw.
        run_draw(0, 1'b0, 10, 72);
        finish_run();
        xpos = 158;
        run_draw(1, 1'b0, -1, 72);
        finish_run();

        // update_screen with draw_start: move first, draw at new x.
        run_draw(1, 1'b1, -1, 72);
        finish_run();

        // Scroll down to column 0, then wrap.
        update_screen = 1'b1;
        repeat (xpos) @(negedge clock);
        update_screen = 1'b0;
        xpos = 0;
        run_draw(0, 1'b0, -1, 72);
        finish_run();
        update_screen = 1'b1;
        @(negedge clock);
        update_screen = 1'b0;
        xpos = 159;
        run_draw(0, 1'b0, -1, 72);
        finish_run();

        // Reset mid-draw at pixel 30 from a moved position.
        update_screen = 1'b1;
        @(negedge clock);
        update_screen = 1'b0;
        xpos = 158;
        run_draw(0, 1'b0, -1, 30);
        resetn     = 1'b0;
        draw_start = 1'b0;
        @(negedge clock);
        chk("reset_mid_draw", obs(), {1'b0, 1'b0, 11'd159, 11'd100, 3'b000});
        resetn = 1'b1;
        xpos   = 159;
        run_draw(0, 1'b0, -1, 72);
        finish_run();

        // Abort by dropping draw_start; draw_done must never rise.
        run_draw(0, 1'b0, -1, 20);
        draw_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("abort_idle", {draw_done, plot}, 2'b00);
        end
        run_draw(0, 1'b0, -1, 72);
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
